// File: rtl/fadd_arbiter.sv
// Two-port round-robin arbiter/sequencer sharing one combinational
// single-precision adder; operands registered, sum held until consumed.

module faddition (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);
    logic [31:0] x, y;
    logic [7:0]  ediff;
    logic [26:0] mx, my, my_sh, norm;
    logic [27:0] sum;
    logic [9:0]  e_n;
    logic [4:0]  lz;
    logic [24:0] rnd;
    logic [22:0] man_o;
    logic        rup;

    always_comb begin
        // Larger magnitude goes to x so the mantissa subtraction never goes negative
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        mx    = {|x[30:23], x[22:0], 3'b000};
        my    = {|y[30:23], y[22:0], 3'b000};
        ediff = x[30:23] - y[30:23];
        if (ediff > 8'd26) begin
            my_sh = {26'd0, |my};
        end else begin
            my_sh = (my >> ediff) | {26'd0, |(my & ~({27{1'b1}} << ediff))};
        end
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, my_sh};
        end else begin
            sum = {1'b0, mx} - {1'b0, my_sh};
        end
        lz = '0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        if (sum[27]) begin
            norm = sum[27:1] | {26'd0, sum[0]};
            e_n  = {2'b00, x[30:23]} + 10'd1;
        end else begin
            norm = sum[26:0] << lz;
            e_n  = {2'b00, x[30:23]} - {5'd0, lz};
        end
        // Round to nearest, ties to even; guard at bit 2, sticky below
        rup = norm[2] & (norm[3] | norm[1] | norm[0]);
        rnd = {1'b0, norm[26:3]} + {24'd0, rup};
        if (rnd[24]) begin
            e_n   = e_n + 10'd1;
            man_o = rnd[23:1];
        end else begin
            man_o = rnd[22:0];
        end
        if (sum == '0) begin
            s = '0;
        end else if (e_n[9] || e_n == 10'd0) begin
            s = {x[31], 31'd0};
        end else if (e_n >= 10'd255) begin
            s = {x[31], 8'hFF, 23'd0};
        end else begin
            s = {x[31], e_n[7:0], man_o};
        end
    end
endmodule

module fadd_arbiter #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic [31:0]     req0_a,
    input  logic [31:0]     req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [31:0]     req1_a,
    input  logic [31:0]     req1_b,
    output logic            req1_ready,
    output logic            rsp0_valid,
    output logic [31:0]     rsp0_s,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    output logic [31:0]     rsp1_s,
    input  logic            rsp1_ready,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic [31:0]     opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic [CNTW-1:0] op_count_q, op_count_d;
    logic [31:0]     sum_w;
    logic            grant0, grant1, rsp_hs;

    faddition u_fadd (.a(opa_q), .b(opb_q), .s(sum_w));

    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    assign rsp_hs = (state_q == S_RESP) & (owner_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        res_d        = res_q;
        op_count_d   = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (grant0 | grant1) begin
                    opa_d   = grant1 ? req1_a : req0_a;
                    opb_d   = grant1 ? req1_b : req0_b;
                    owner_d = grant1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                res_d   = sum_w;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_hs) begin
                    last_grant_d = owner_q;
                    op_count_d   = op_count_q + CNTW'(1);
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            res_q        <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            res_q        <= res_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req0_ready = (state_q == S_IDLE) & grant0;
    assign req1_ready = (state_q == S_IDLE) & grant1;
    assign rsp0_valid = (state_q == S_RESP) & ~owner_q;
    assign rsp1_valid = (state_q == S_RESP) & owner_q;
    assign rsp0_s     = res_q;
    assign rsp1_s     = res_q;
    assign busy       = (state_q != S_IDLE);
    assign op_count   = op_count_q;
endmodule

// File: tb/tb_fadd_arbiter.sv
// Scoreboard bench for fadd_arbiter: expected sums queued at request
// handshake, popped and compared at response handshake.

module tb_fadd_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_s, rsp1_s;
    logic        busy;
    logic [3:0]  op_count;

    logic [31:0] exp0_s, exp1_s;
    logic [32:0] sb[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fadd_arbiter #(.CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_s(rsp0_s), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_s(rsp1_s), .rsp1_ready(rsp1_ready),
        .busy(busy), .op_count(op_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input logic port, input logic [31:0] s);
        logic [32:0] e;
        check_eq("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("rsp_port", {31'd0, port}, {31'd0, e[32]});
            check_eq("rsp_sum", s, e[31:0]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (req0_valid && req0_ready) sb.push_back({1'b0, exp0_s});
            if (req1_valid && req1_ready) sb.push_back({1'b1, exp1_s});
            if (rsp0_valid && rsp1_valid) check_eq("rsp_both_valid", 32'd1, 32'd0);
            if (rsp0_valid && rsp0_ready) pop_check(1'b0, rsp0_s);
            if (rsp1_valid && rsp1_ready) pop_check(1'b1, rsp1_s);
        end
    end

    task automatic wait_ready(input logic port);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) return;
        end
        check_eq("ready_timeout", {31'd0, port ? req1_ready : req0_ready}, 32'd1);
    endtask

    task automatic wait_rsp(input logic port);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (port ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready)) return;
        end
        check_eq("rsp_timeout", {31'd0, port ? rsp1_valid : rsp0_valid}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1 check_eq("rst_count", {28'd0, op_count}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic do_op(input logic port, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s);
        @(posedge clk);
        #1;
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; exp1_s = s;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; exp0_s = s;
        end
        wait_ready(port);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(port);
        @(negedge clk);
    endtask

    logic [31:0] va[4], vb[4], vs[4];

    initial begin
        va[0] = 32'h3F800000; vb[0] = 32'h40000000; vs[0] = 32'h40400000;
        va[1] = 32'h3F800000; vb[1] = 32'h3F800000; vs[1] = 32'h40000000;
        va[2] = 32'h40A00000; vb[2] = 32'hC0400000; vs[2] = 32'h40000000;
        va[3] = 32'h41200000; vb[3] = 32'h3F000000; vs[3] = 32'h41280000;
        exp0_s = '0; exp1_s = '0;

        // Reset with random inputs
        rst_n = 1'b0;
        req0_valid = 1'($urandom); req1_valid = 1'($urandom);
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check_eq("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_count", {28'd0, op_count}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_eq("rst_prio_ready0", {31'd0, req0_ready}, 32'd1);
        check_eq("rst_prio_ready1", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Single add with exact latency
        @(posedge clk);
        #1 req0_valid = 1'b1; req0_a = va[0]; req0_b = vb[0]; exp0_s = vs[0];
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        wait_ready(1'b0);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        check_eq("single_calc_busy", {31'd0, busy}, 32'd1);
        check_eq("single_calc_valid", {31'd0, rsp0_valid}, 32'd0);
        @(negedge clk);
        check_eq("single_resp_valid", {31'd0, rsp0_valid}, 32'd1);
        check_eq("single_resp_sum", rsp0_s, 32'h40400000);
        check_eq("single_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        @(negedge clk);
        check_eq("single_done_valid", {31'd0, rsp0_valid}, 32'd0);
        check_eq("single_done_busy", {31'd0, busy}, 32'd0);
        check_eq("single_count", {28'd0, op_count}, 32'd1);

        // Contention: grants alternate 0,1,0,1 every 3 cycles
        do_reset();
        @(posedge clk);
        #1 req0_a = va[1]; req0_b = vb[1]; exp0_s = vs[1];
        req1_a = va[2]; req1_b = vb[2]; exp1_s = vs[2];
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check_eq("alt_ready0", {31'd0, req0_ready}, {31'd0, (c % 3 == 0) && ((c / 3) % 2 == 0)});
            check_eq("alt_ready1", {31'd0, req1_ready}, {31'd0, (c % 3 == 0) && ((c / 3) % 2 == 1)});
        end
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check_eq("alt_count", {28'd0, op_count}, 32'd4);
        check_eq("alt_sb_empty", 32'(sb.size()), 32'd0);

        // Back-pressure on port 1 while port 0 waits
        rsp1_ready = 1'b0;
        @(posedge clk);
        #1 req1_valid = 1'b1; req1_a = va[3]; req1_b = vb[3]; exp1_s = vs[3];
        wait_ready(1'b1);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = va[0]; req0_b = vb[0]; exp0_s = vs[0];
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_valid", {31'd0, rsp1_valid}, 32'd1);
            check_eq("bp_sum", rsp1_s, 32'h41280000);
            check_eq("bp_ready0", {31'd0, req0_ready}, 32'd0);
            check_eq("bp_ready1", {31'd0, req1_ready}, 32'd0);
            check_eq("bp_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        #1 rsp1_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_count_hold", {28'd0, op_count}, 32'd4);
        @(negedge clk);
        check_eq("bp_release_ready0", {31'd0, req0_ready}, 32'd1);
        check_eq("bp_count", {28'd0, op_count}, 32'd5);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_rsp(1'b0);
        @(negedge clk);
        check_eq("bp_count2", {28'd0, op_count}, 32'd6);

        // Reset during CALC, then during RESP
        rsp0_ready = 1'b0;
        for (int ph = 0; ph < 2; ph++) begin
            @(posedge clk);
            #1 req0_valid = 1'b1; req0_a = va[1]; req0_b = vb[1]; exp0_s = vs[1];
            wait_ready(1'b0);
            @(posedge clk);
            #1 req0_valid = 1'b0;
            repeat (ph + 1) @(negedge clk);
            #2 rst_n = 1'b0;
            sb.delete();
            #1;
            check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
            check_eq("mid_rst_valid", {31'd0, rsp0_valid}, 32'd0);
            check_eq("mid_rst_count", {28'd0, op_count}, 32'd0);
            @(negedge clk);
            #2 rst_n = 1'b1;
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            check_eq("mid_rst_prio0", {31'd0, req0_ready}, 32'd1);
            check_eq("mid_rst_prio1", {31'd0, req1_ready}, 32'd0);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        rsp0_ready = 1'b1;

        // Counter wrap with 4-bit counter: 17 operations
        for (int i = 1; i <= 17; i++) begin
            do_op(1'(i % 2), va[i % 4], vb[i % 4], vs[i % 4]);
            if (i >= 15) check_eq("wrap_count", {28'd0, op_count}, 32'(i % 16));
        end
        check_eq("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
